// File: rtl/line_window_buffer_if.sv
// Pixel-stream / column-output bundle for line_window_buffer.
// master = pixel source / column consumer, slave = the buffer itself.
interface line_window_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 3,
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0]       cfg_width;
    logic                        in_sof;
    logic                        in_valid;
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        out_valid;
    logic [LINES*DATA_WIDTH-1:0] out_col;
    logic [ADDR_WIDTH-1:0]       out_row;
    logic [ADDR_WIDTH-1:0]       out_colidx;
    logic                        out_win_ok;

    modport master (
        output cfg_width, in_sof, in_valid, in_data,
        input  out_valid, out_col, out_row, out_colidx, out_win_ok
    );

    modport slave (
        input  cfg_width, in_sof, in_valid, in_data,
        output out_valid, out_col, out_row, out_colidx, out_win_ok
    );
endinterface

// File: rtl/line_window_buffer.sv
// Multi-line buffer: for every accepted raster pixel emits a vertical column
// of LINES pixels (slice k = pixel k rows above), one cycle later.
// Rows not yet received are zero-filled or replicate row 0 (BORDER_MODE).
module line_window_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 3,
    parameter int MAX_WIDTH   = 1024,
    parameter int ADDR_WIDTH  = 11,
    parameter int BORDER_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    line_window_buffer_if.slave bus
);
    localparam int NMEM = LINES - 1;
    localparam int MA   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] WMAX = ADDR_WIDTH'(MAX_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] RSAT = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    // line_mem[j][c] holds pixel(r-1-j, c) relative to the row being received
    logic [DATA_WIDTH-1:0] line_mem [NMEM][MAX_WIDTH];

    logic [ADDR_WIDTH-1:0] row_q, col_q, width_q;
    logic [ADDR_WIDTH-1:0] row_e, col_e, width_e, cfg_w;
    logic [MA-1:0]         addr;
    logic [NMEM-1:0][DATA_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0]            fill;
    logic [LINES-1:0][DATA_WIDTH-1:0] col_d;

    // width 0 or beyond storage depth falls back to full depth
    assign cfg_w = (bus.cfg_width == '0 || bus.cfg_width > WMAX) ? WMAX : bus.cfg_width;
    assign addr  = col_e[MA-1:0];

    // sof forces this pixel to (0,0) and uses the freshly sampled width
    always_comb begin
        row_e   = row_q;
        col_e   = col_q;
        width_e = width_q;
        if (bus.in_sof) begin
            row_e   = '0;
            col_e   = '0;
            width_e = cfg_w;
        end
    end

    // asynchronous read of every line at the current column (old contents)
    for (genvar j = 0; j < NMEM; j++) begin : g_rd
        assign rd[j] = line_mem[j][addr];
    end

    // replicate-border source: pixel(0,c) sits in line r-1, or is p when r=0
    always_comb begin
        fill = bus.in_data;
        for (int j = 0; j < NMEM; j++)
            if (row_e == ADDR_WIDTH'(j + 1)) fill = rd[j];
    end

    // assemble the output column; missing rows get the border value
    always_comb begin
        col_d    = '0;
        col_d[0] = bus.in_data;
        for (int k = 1; k < LINES; k++) begin
            if (row_e >= ADDR_WIDTH'(k))
                col_d[k] = rd[k-1];
            else if (BORDER_MODE != 0)
                col_d[k] = fill;
            else
                col_d[k] = '0;
        end
    end

    // shift the column down through the line memories (read-before-write)
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            line_mem[0][addr] <= bus.in_data;
            for (int j = 1; j < NMEM; j++)
                line_mem[j][addr] <= rd[j-1];
        end
    end

    // position counters and registered outputs; outputs hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q          <= '0;
            col_q          <= '0;
            width_q        <= WMAX;
            bus.out_valid  <= 1'b0;
            bus.out_col    <= '0;
            bus.out_row    <= '0;
            bus.out_colidx <= '0;
            bus.out_win_ok <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                width_q <= width_e;
                if (col_e == width_e - ONE) begin
                    col_q <= '0;
                    row_q <= (row_e == RSAT) ? row_e : row_e + ONE;
                end else begin
                    col_q <= col_e + ONE;
                    row_q <= row_e;
                end
                bus.out_col    <= col_d;
                bus.out_row    <= row_e;
                bus.out_colidx <= col_e;
                bus.out_win_ok <= (row_e >= ADDR_WIDTH'(LINES - 1));
            end
        end
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench: two buffers (zero-fill and replicate border) share one
// pixel stream; expected columns are queued at issue and popped by monitors.
module tb_line_window_buffer;
    localparam int DW = 8, L = 3, MW = 1024, AW = 11;

    typedef struct packed {
        logic [L*DW-1:0] col;
        logic [AW-1:0]   row;
        logic [AW-1:0]   cidx;
        logic            ok;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_window_buffer_if #(.DATA_WIDTH(DW), .LINES(L), .ADDR_WIDTH(AW)) b0 ();
    line_window_buffer_if #(.DATA_WIDTH(DW), .LINES(L), .ADDR_WIDTH(AW)) b1 ();

    line_window_buffer #(.DATA_WIDTH(DW), .LINES(L), .MAX_WIDTH(MW), .ADDR_WIDTH(AW), .BORDER_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    line_window_buffer #(.DATA_WIDTH(DW), .LINES(L), .MAX_WIDTH(MW), .ADDR_WIDTH(AW), .BORDER_MODE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int tests = 0, fails = 0, vcnt0 = 0;
    exp_t q0[$], q1[$];
    logic [DW-1:0]   frm  [int];
    logic [L*DW-1:0] log0 [int];
    logic [L*DW-1:0] log1 [int];
    int mr, mc, mw;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [L*DW-1:0] lg(input int which, input int r, input int c);
        int key = r * 4096 + c;
        if (which == 0) return log0.exists(key) ? log0[key] : 'x;
        return log1.exists(key) ? log1[key] : 'x;
    endfunction

    task automatic drive(input logic sof, input logic vld, input logic [AW-1:0] cfg, input logic [DW-1:0] d);
        b0.in_sof = sof; b0.in_valid = vld; b0.cfg_width = cfg; b0.in_data = d;
        b1.in_sof = sof; b1.in_valid = vld; b1.cfg_width = cfg; b1.in_data = d;
    endtask

    task automatic model_reset();
        mr = 0; mc = 0; mw = MW;
        frm.delete();
    endtask

    // issue one pixel, queue its expected column for both border modes
    task automatic px(input logic sof, input logic [AW-1:0] cfg, input logic [DW-1:0] d);
        exp_t e0, e1;
        if (sof) begin
            mr = 0; mc = 0;
            mw = (cfg == 0 || int'(cfg) > MW) ? MW : int'(cfg);
            frm.delete();
        end
        frm[mr * 4096 + mc] = d;
        e0 = '0;
        e0.row = AW'(mr); e0.cidx = AW'(mc); e0.ok = (mr >= L - 1);
        e1 = e0;
        for (int k = 0; k < L; k++) begin
            if (mr >= k) begin
                e0.col[k*DW +: DW] = frm[(mr - k) * 4096 + mc];
                e1.col[k*DW +: DW] = frm[(mr - k) * 4096 + mc];
            end else begin
                e0.col[k*DW +: DW] = '0;
                e1.col[k*DW +: DW] = frm[mc];
            end
        end
        q0.push_back(e0);
        q1.push_back(e1);
        drive(sof, 1'b1, cfg, d);
        @(posedge clk); #1;
        if (mc == mw - 1) begin
            mc = 0;
            if (mr < (1 << AW) - 1) mr++;
        end else mc++;
        drive(1'b0, 1'b0, cfg, d);
    endtask

    // idle cycles; a stray sof without valid must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, AW'(2), 8'hEE);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, AW'(2), 8'hEE);
    endtask

    task automatic ramp(input bit gaps);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (gaps) while ($urandom_range(0, 9) < 3) idle(1);
                px(r == 0 && c == 0, AW'(4), DW'(16 * r + c));
            end
        idle(2);
    endtask

    // monitors: pop and compare on every presented column
    always @(negedge clk) begin
        exp_t g, e;
        if (b0.out_valid) begin
            vcnt0++;
            g = {b0.out_col, b0.out_row, b0.out_colidx, b0.out_win_ok};
            log0[int'(b0.out_row) * 4096 + int'(b0.out_colidx)] = b0.out_col;
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL zero_fill_unexpected got=%h", g);
            end else begin
                e = q0.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL zero_fill_col got col=%h row=%0d c=%0d ok=%b exp col=%h row=%0d c=%0d ok=%b",
                             g.col, g.row, g.cidx, g.ok, e.col, e.row, e.cidx, e.ok);
                end
            end
        end
        if (b1.out_valid) begin
            g = {b1.out_col, b1.out_row, b1.out_colidx, b1.out_win_ok};
            log1[int'(b1.out_row) * 4096 + int'(b1.out_colidx)] = b1.out_col;
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL replicate_unexpected got=%h", g);
            end else begin
                e = q1.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL replicate_col got col=%h row=%0d c=%0d ok=%b exp col=%h row=%0d c=%0d ok=%b",
                             g.col, g.row, g.cidx, g.ok, e.col, e.row, e.cidx, e.ok);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, '0, '0);
        model_reset();
        // 1: reset with toggling input, then a sof-less first pixel
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'(i % 2 == 0), AW'(4), 8'h5A);
            @(negedge clk);
            chk("reset_outputs", 64'({b0.out_valid, b0.out_col, b0.out_row, b0.out_colidx, b0.out_win_ok,
                                      b1.out_valid, b1.out_col, b1.out_row, b1.out_colidx, b1.out_win_ok}), 64'd0);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        px(1'b0, AW'(4), 8'h11);
        idle(2);
        chk("first_px_zero", 64'(lg(0, 0, 0)), 64'h000011);
        chk("first_px_repl", 64'(lg(1, 0, 0)), 64'h111111);

        // 2/3: continuous ramp frame, width 4
        ramp(1'b0);
        chk("ramp_2_1", 64'(lg(0, 2, 1)), 64'h011121);
        chk("ramp_3_3", 64'(lg(0, 3, 3)), 64'h132333);
        chk("repl_1_2", 64'(lg(1, 1, 2)), 64'h020212);
        chk("repl_0_0", 64'(lg(1, 0, 0)), 64'h000000);

        // 4: same frame with idle gaps
        vcnt0 = 0;
        ramp(1'b1);
        chk("gap_valid_count", 64'(vcnt0), 64'd16);
        chk("gap_2_1", 64'(lg(0, 2, 1)), 64'h011121);

        // 5: sof in the middle of row 2, new width 2; cfg changes ignored
        for (int i = 0; i < 10; i++)
            px(i == 0, (i == 0) ? AW'(4) : AW'(7), DW'(16 * (i / 4) + i % 4));
        px(1'b1, AW'(2), 8'hA0);
        for (int i = 1; i < 6; i++) px(1'b0, AW'(7), DW'(8'hA0 + i));
        idle(2);
        chk("midsof_0_0", 64'(lg(0, 0, 0)), 64'h0000A0);
        chk("midsof_1_0", 64'(lg(0, 1, 0)), 64'h00A0A2);
        chk("midsof_2_0", 64'(lg(0, 2, 0)), 64'hA0A2A4);

        // 6: width 0 selects full depth; wrap at MAX_WIDTH-1
        for (int i = 0; i < MW + 2; i++) px(i == 0, (i == 0) ? AW'(0) : AW'(5), DW'(i ^ (i >> 8)));
        idle(2);
        chk("full_0_1023", 64'(lg(0, 0, MW - 1)), 64'h0000FC);
        chk("full_1_0", 64'(lg(0, 1, 0)), 64'h000004);
        chk("full_1_1", 64'(lg(0, 1, 1)), 64'h000105);

        // mid-frame reset: immediate clear, next pixel restarts at (0,0)
        px(1'b1, AW'(4), 8'h31);
        px(1'b0, AW'(4), 8'h32);
        idle(1);
        rst_n = 1'b0;
        #2;
        chk("midreset_clear", 64'({b0.out_valid, b0.out_col, b0.out_row, b0.out_colidx, b1.out_col}), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        px(1'b0, AW'(4), 8'h55);
        px(1'b0, AW'(4), 8'h56);
        idle(2);
        chk("after_reset_repl", 64'(lg(1, 0, 0)), 64'h555555);

        chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
Parametrised multi-line buffer that turns a raster pixel stream into a vertical column of LINES vertically aligned pixels per accepted input pixel.
It feeds the 3x3 (generally LINES x LINES) matrix/convolution stage, which builds the horizontal window with its own shift registers.
Single clock domain. Line length is runtime-configurable up to MAX_WIDTH. Rows not yet received are filled according to a border mode.

Parameters:
DATA_WIDTH, 8, pixel width in bits
LINES, 3, column height (rows delivered per output), legal 2..8
MAX_WIDTH, 1024, maximum pixels per line; sets line storage depth
ADDR_WIDTH, 11, width of column counter and cfg_width; must satisfy 2^ADDR_WIDTH > MAX_WIDTH
BORDER_MODE, 0, 0 = zero-fill missing rows, 1 = replicate row 0

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_width  input  ADDR_WIDTH  active line length; sampled on an accepted in_sof pixel; 0 or >MAX_WIDTH means MAX_WIDTH
in_sof  input  1  first pixel of frame; qualified by in_valid
in_valid  input  1  pixel strobe; no backpressure, gaps allowed
in_data  input  DATA_WIDTH  pixel
out_valid  output  1  out_col valid
out_col  output  LINES*DATA_WIDTH  slice k (bits k*DATA_WIDTH +: DATA_WIDTH) = pixel k rows above the current pixel
out_row  output  ADDR_WIDTH  row index of current pixel, saturating at 2^ADDR_WIDTH-1
out_colidx  output  ADDR_WIDTH  column index of current pixel
out_win_ok  output  1  high when out_row >= LINES-1, i.e. all slices hold real pixels

Behaviour:
- Interface: clk, asynchronous active-low rst_n, all logic on rising edge of clk.
- Reset: all outputs 0. Column counter 0, row counter 0, active width = MAX_WIDTH. Line storage contents are don't-care; storage validity is tracked by the row counter only.
- Latency: exactly 1 cycle. An accepted pixel in cycle t produces out_valid=1 in cycle t+1 with its data. out_valid=0 in every cycle following a cycle with in_valid=0. Outputs hold their last value while out_valid=0.
- Accepted pixel p at (row r, col c):
  - out_col slice 0 = p.
  - Slice k (1..LINES-1) = pixel(r-k, c) if r >= k.
  - If r < k: 0 when BORDER_MODE=0; pixel(0,c) when BORDER_MODE=1. For r = 0 that is p itself.
- Storage: LINES-1 line memories of MAX_WIDTH x DATA_WIDTH, read and written at column c on each accepted pixel. Line j receives the value read from line j-1; line 0 receives p. Read-before-write at the same address within a cycle.
- Counters:
  - c increments per accepted pixel. At c = width-1 it wraps to 0 and r increments, saturating at 2^ADDR_WIDTH-1.
  - out_win_ok uses the pre-increment r.
- in_sof with in_valid: r=0 and c=0 are forced for this pixel, overriding the current counter state (mid-line sof allowed). cfg_width is latched in the same cycle. Border fill restarts. The pixel is output as (0,0).
- in_sof without in_valid: ignored.
- cfg_width changes without sof: ignored until the next sof.
- rst_n asserted mid-frame: immediate clear. The first pixel after release is treated as (0,0) even without in_sof.
- No gap-dependent behaviour: timing between pixels, including across line boundaries, never affects data.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid toggling -> all outputs 0. Release, then one pixel 0x11 -> out_valid next cycle, out_col slice0=0x11, slices1..2=0 (BORDER_MODE=0), out_row=0, out_colidx=0, out_win_ok=0.
2. Ramp frame: sof, cfg_width=4, LINES=3, pixels value=16*r+c for 4 rows continuous -> at (2,1) out_col = {0x01,0x11,0x21} (slice2..0), out_win_ok=1. At (3,3) out_col = {0x13,0x23,0x33}.
3. Same frame with BORDER_MODE=1 -> at (1,2) out_col = {0x02,0x02,0x12}. At (0,0) all slices = 0x00.
4. Random in_valid gaps (30% idle) on test 2 stream -> out_col sequence identical to test 2 per accepted pixel; out_valid count equals 16.
5. Mid-line sof: at (2,2) assert sof with cfg_width=2 -> that pixel reported as row 0 col 0, slices1..2 = 0; wrap occurs after 2 pixels.
6. cfg_width=0 -> line length MAX_WIDTH. Check wrap at col MAX_WIDTH-1 and that out_row increments exactly there.
